lsm_addr_gen: RTL and testbench
===============================

LSM_ADDR_GEN -- requirements
Module: lsm_addr_gen

Interface
REQ-001 SHALL have: CLK  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have: CLR  input  1  reset, synchronous and active-high.
REQ-003 SHALL have: START  input  1  begin a load/store-multiple sequence; sampled only in IDLE.
REQ-004 SHALL have: IR  input  32  instruction; P=IR[24], U=IR[23], W=IR[21], L=IR[20], register list=IR[15:0].
REQ-005 SHALL have: BASE  input  32  value of Rn; sampled with START.
REQ-006 SHALL have: MOC  input  1  memory operation complete; ends the current transfer.
REQ-007 SHALL have: MEM_REQ  output  1  memory request for the current transfer.
REQ-008 SHALL have: MEM_RW  output  1  1 = read (LDM, L=1), 0 = write (STM).
REQ-009 SHALL have: MAR_OUT  output  32  word address of the current transfer.
REQ-010 SHALL have: REG_NUM  output  4  register number of the current transfer.
REQ-011 SHALL have: BUSY  output  1  high in every state except IDLE.
REQ-012 SHALL have: DONE  output  1  one-cycle completion pulse.
REQ-013 SHALL have: WB_EN  output  1  one-cycle Rn writeback strobe.
REQ-014 SHALL have: WB_VALUE  output  32  new Rn value, valid while WB_EN=1.

Function
REQ-015 SHALL have states IDLE, CALC, XFER, GAP, WB and DONE.
REQ-016 In IDLE, START=1 SHALL latch IR and BASE and move to CALC; START SHALL be ignored in all other states.
REQ-017 In CALC, the block SHALL compute N = popcount(list) and the start address: IA (P=0,U=1) = BASE; IB (P=1,U=1) = BASE+4; DA (P=0,U=0) = BASE-4N+4; DB (P=1,U=0) = BASE-4N.
REQ-018 CALC SHALL go to DONE if list=0; otherwise it SHALL go to XFER with REG_NUM set to the lowest set bit.
REQ-019 XFER SHALL hold MEM_REQ=1 with stable MAR_OUT, REG_NUM and MEM_RW=L until MOC=1.
REQ-020 On MOC in XFER, the block SHALL clear the serviced bit and add 4 to MAR_OUT.
REQ-021 After that MOC, XFER SHALL go to GAP if bits remain, to WB if none remain and W=1, and to DONE otherwise.
REQ-022 GAP SHALL hold MEM_REQ=0 for exactly one cycle, set REG_NUM to the next lowest set bit, and return to XFER.
REQ-023 Registers SHALL always transfer in ascending number order at ascending addresses, regardless of U.
REQ-024 WB SHALL assert WB_EN for one cycle with WB_VALUE = BASE+4N if U=1, else BASE-4N, then go to DONE.
REQ-025 DONE SHALL assert DONE for one cycle, then go to IDLE.
REQ-026 All address arithmetic SHALL be modulo 2^32; wrap-around is not an error.
REQ-027 MOC SHALL be ignored outside XFER.
REQ-028 An empty list SHALL cause no memory request and no writeback, even with W=1.
REQ-029 Rn appearing in the list SHALL get no special treatment.
REQ-030 Latency: DONE SHALL be high in cycle k+2 after START is sampled at edge k when list=0.

Reset
REQ-031 CLR=1 SHALL force IDLE on the next edge from any state, including mid-transfer, and SHALL abandon the sequence without a DONE pulse.
REQ-032 During and after reset, MEM_REQ, MEM_RW, BUSY, DONE and WB_EN SHALL be 0, and MAR_OUT, REG_NUM and WB_VALUE SHALL be 0.

Configuration
REQ-033 Macro LSM_WRITEBACK_EN defined: the WB state and WB_EN/WB_VALUE SHALL behave per REQ-021 and REQ-024.
REQ-034 Macro LSM_WRITEBACK_EN undefined: WB SHALL never be entered, W SHALL be ignored, and WB_EN and WB_VALUE SHALL be constant 0.

Verification
REQ-035 STMIA (P=0,U=1,L=0,W=1), BASE=0x100, list=0x0005 -> R0@0x100, R2@0x104, MEM_RW=0, WB_VALUE=0x108, DONE.
REQ-036 LDMDB (P=1,U=0,L=1,W=1), BASE=0x200, list=0x8001 -> R0@0x1F8, R15@0x1FC, MEM_RW=1, WB_VALUE=0x1F8.
REQ-037 LDMIB, BASE=0x1000, list=0xFFFF, W=0 -> 16 transfers 0x1004..0x1040 with one GAP cycle between each, no WB_EN, then DONE.
REQ-038 STMIA, BASE=0xFFFFFFFC, list=0x0003, W=1 -> 0xFFFFFFFC, then 0x00000000, WB_VALUE=0x00000004.
REQ-039 list=0x0000, W=1 -> no MEM_REQ, no WB_EN, DONE high exactly 2 cycles after START is sampled.
REQ-040 CLR asserted while in XFER awaiting MOC -> next cycle IDLE with all outputs 0 and no DONE; a new START then runs normally.

Source files
------------

// File: rtl/lsm_addr_gen.sv
// Address/sequence generator for ARM-style load/store-multiple (LDM/STM) transfers.
// Optional Rn writeback is compiled in by defining LSM_WRITEBACK_EN.
module lsm_addr_gen (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        START,
    input  logic [31:0] IR,
    input  logic [31:0] BASE,
    input  logic        MOC,
    output logic        MEM_REQ,
    output logic        MEM_RW,
    output logic [31:0] MAR_OUT,
    output logic [3:0]  REG_NUM,
    output logic        BUSY,
    output logic        DONE,
    output logic        WB_EN,
    output logic [31:0] WB_VALUE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_XFER,
        S_GAP,
        S_WB,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic        p_q, u_q, l_q;
    logic [15:0] list_q;
    logic [31:0] base_q;

    logic [4:0]  n_count;
    logic [31:0] span;
    logic [31:0] start_addr;
    logic [15:0] list_left;
    logic [3:0]  low_bit;

    function automatic logic [3:0] lowest_bit(input logic [15:0] v);
        lowest_bit = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_bit = 4'(i);
        end
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] v);
        popcount = 5'd0;
        for (int i = 0; i < 16; i++) begin
            popcount = popcount + 5'(v[i]);
        end
    endfunction

    assign n_count   = popcount(list_q);
    assign span      = {25'd0, n_count, 2'b00};
    assign low_bit   = lowest_bit(list_q);
    assign list_left = list_q & ~(16'd1 << REG_NUM);

    // Transfers always ascend, so decrementing modes start at the lowest address of the block.
    always_comb begin
        unique case ({p_q, u_q})
            2'b01:   start_addr = base_q;
            2'b11:   start_addr = base_q + 32'd4;
            2'b00:   start_addr = base_q - span + 32'd4;
            default: start_addr = base_q - span;
        endcase
    end

`ifdef LSM_WRITEBACK_EN
    logic        w_q;
    logic [4:0]  n_q;
    logic [31:0] wb_span;
    logic        unused_ir;

    assign wb_span   = {25'd0, n_q, 2'b00};
    assign unused_ir = ^{IR[31:25], IR[22], IR[19:16]};
`else
    logic unused_ir;

    assign unused_ir = ^{IR[31:25], IR[22:21], IR[19:16]};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the datapath registers are cleared along with the state, because
    // MAR_OUT and REG_NUM are directly visible outputs that must read 0 in reset.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            p_q     <= 1'b0;
            u_q     <= 1'b0;
            l_q     <= 1'b0;
            list_q  <= 16'd0;
            base_q  <= 32'd0;
            MAR_OUT <= 32'd0;
            REG_NUM <= 4'd0;
`ifdef LSM_WRITEBACK_EN
            w_q     <= 1'b0;
            n_q     <= 5'd0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        p_q    <= IR[24];
                        u_q    <= IR[23];
                        l_q    <= IR[20];
                        list_q <= IR[15:0];
                        base_q <= BASE;
`ifdef LSM_WRITEBACK_EN
                        w_q    <= IR[21];
`endif
                    end
                end
                S_CALC: begin
                    MAR_OUT <= start_addr;
                    REG_NUM <= low_bit;
`ifdef LSM_WRITEBACK_EN
                    n_q     <= n_count;
`endif
                end
                S_XFER: begin
                    if (MOC) begin
                        list_q  <= list_left;
                        MAR_OUT <= MAR_OUT + 32'd4;
                    end
                end
                S_GAP: begin
                    REG_NUM <= low_bit;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output and next-state value gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        MEM_REQ    = 1'b0;
        MEM_RW     = 1'b0;
        BUSY       = (state != S_IDLE);
        DONE       = 1'b0;
        WB_EN      = 1'b0;
        WB_VALUE   = 32'd0;

        unique case (state)
            S_IDLE: begin
                if (START) state_next = S_CALC;
            end
            S_CALC: begin
                state_next = (list_q == 16'd0) ? S_DONE : S_XFER;
            end
            S_XFER: begin
                MEM_REQ = 1'b1;
                MEM_RW  = l_q;
                if (MOC) begin
                    if (list_left != 16'd0) begin
                        state_next = S_GAP;
                    end else begin
`ifdef LSM_WRITEBACK_EN
                        state_next = w_q ? S_WB : S_DONE;
`else
                        state_next = S_DONE;
`endif
                    end
                end
            end
            S_GAP: begin
                state_next = S_XFER;
            end
            S_WB: begin
`ifdef LSM_WRITEBACK_EN
                WB_EN    = 1'b1;
                WB_VALUE = u_q ? (base_q + wb_span) : (base_q - wb_span);
`endif
                state_next = S_DONE;
            end
            S_DONE: begin
                DONE       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsm_addr_gen.sv
// Directed self-checking bench for lsm_addr_gen; expected addresses and values are hand-computed.
// Writeback expectations follow LSM_WRITEBACK_EN in the same way as the design.
module tb_lsm_addr_gen;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        START;
    logic [31:0] IR;
    logic [31:0] BASE;
    logic        MOC;
    logic        MEM_REQ;
    logic        MEM_RW;
    logic [31:0] MAR_OUT;
    logic [3:0]  REG_NUM;
    logic        BUSY;
    logic        DONE;
    logic        WB_EN;
    logic [31:0] WB_VALUE;

    int checks = 0;
    int errors = 0;

    lsm_addr_gen dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .START    (START),
        .IR       (IR),
        .BASE     (BASE),
        .MOC      (MOC),
        .MEM_REQ  (MEM_REQ),
        .MEM_RW   (MEM_RW),
        .MAR_OUT  (MAR_OUT),
        .REG_NUM  (REG_NUM),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .WB_EN    (WB_EN),
        .WB_VALUE (WB_VALUE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(input bit p, input bit u, input bit w, input bit l,
                                          input logic [15:0] list);
        mk_ir = {4'hE, 3'b100, p, u, 1'b0, w, l, 4'h3, list};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " mem_req"},  32'(MEM_REQ),  32'd0);
        check({tag, " mem_rw"},   32'(MEM_RW),   32'd0);
        check({tag, " busy"},     32'(BUSY),     32'd0);
        check({tag, " done"},     32'(DONE),     32'd0);
        check({tag, " wb_en"},    32'(WB_EN),    32'd0);
        check({tag, " mar_out"},  MAR_OUT,       32'd0);
        check({tag, " reg_num"},  32'(REG_NUM),  32'd0);
        check({tag, " wb_value"}, WB_VALUE,      32'd0);
    endtask

    // Runs one sequence with a simple memory responder and checks the observed
    // transfer order, addresses, gaps, writeback and completion.
    task automatic run_seq(input string tag, input logic [31:0] ir, input logic [31:0] base,
                           input int moc_wait, input bit noise, input bit hold_start,
                           input logic [31:0] exp_first, input bit exp_rw,
                           input bit exp_wb, input logic [31:0] exp_wb_val,
                           input int exp_latency);
        logic [31:0] addr_q[$];
        int          reg_q[$];
        int          rw_bad = 0, unstable = 0, gap_bad = 0;
        int          wb_cnt = 0, done_cnt = 0, done_c = 0;
        int          gap_len = 0, wait_c = 0, k = 0;
        bit          in_xfer = 1'b0;
        logic [31:0] wb_seen = 32'd0;
        logic [31:0] cur_addr = 32'd0;
        logic [3:0]  cur_reg = 4'd0;
        logic [15:0] list;

        list = ir[15:0];
        @(negedge CLK);
        START = 1'b1;
        IR    = ir;
        BASE  = base;
        MOC   = 1'b0;
        @(negedge CLK);
        START = hold_start;
        IR    = 32'hDEAD_BEEF;
        BASE  = 32'h1234_5678;

        for (int c = 1; c <= 400; c++) begin
            MOC = 1'b0;
            if (MEM_REQ) begin
                if (!in_xfer) begin
                    if (addr_q.size() > 0 && gap_len != 1) gap_bad++;
                    addr_q.push_back(MAR_OUT);
                    reg_q.push_back(int'(REG_NUM));
                    if (MEM_RW !== exp_rw) rw_bad++;
                    cur_addr = MAR_OUT;
                    cur_reg  = REG_NUM;
                    in_xfer  = 1'b1;
                    wait_c   = 0;
                end else if (MAR_OUT !== cur_addr || REG_NUM !== cur_reg || MEM_RW !== exp_rw) begin
                    unstable++;
                end
                if (wait_c >= moc_wait) begin
                    MOC     = 1'b1;
                    in_xfer = 1'b0;
                    gap_len = 0;
                end else begin
                    wait_c++;
                end
            end else begin
                MOC     = noise;
                in_xfer = 1'b0;
                gap_len++;
            end
            if (WB_EN) begin
                wb_cnt++;
                wb_seen = WB_VALUE;
            end
            if (DONE) begin
                done_cnt++;
                done_c = c;
                START  = 1'b0;
                @(negedge CLK);
                MOC = 1'b0;
                break;
            end
            @(negedge CLK);
        end
        MOC = 1'b0;

        check({tag, " done_pulse"}, 32'(done_cnt), 32'd1);
        check({tag, " idle_after"}, 32'(BUSY), 32'd0);
        check({tag, " n_xfer"}, 32'(addr_q.size()), 32'($countones(list)));
        for (int i = 0; i < 16; i++) begin
            if (list[i] && k < addr_q.size()) begin
                check($sformatf("%s r%0d num", tag, i), 32'(reg_q[k]), 32'(i));
                check($sformatf("%s r%0d addr", tag, i), addr_q[k], exp_first + 32'(4 * k));
                k++;
            end
        end
        if (addr_q.size() > 0) begin
            check({tag, " rw"},     32'(rw_bad),   32'd0);
            check({tag, " stable"}, 32'(unstable), 32'd0);
            check({tag, " gaps"},   32'(gap_bad),  32'd0);
        end
`ifdef LSM_WRITEBACK_EN
        check({tag, " wb_count"}, 32'(wb_cnt), exp_wb ? 32'd1 : 32'd0);
        if (exp_wb) check({tag, " wb_value"}, wb_seen, exp_wb_val);
`else
        check({tag, " wb_count"}, 32'(wb_cnt), 32'd0);
        if (exp_wb) check({tag, " wb_value_off"}, WB_VALUE | exp_wb_val, exp_wb_val);
`endif
        if (exp_latency > 0) check({tag, " latency"}, 32'(done_c), 32'(exp_latency));
    endtask

    initial begin
        CLR   = 1'b1;
        START = 1'b0;
        IR    = 32'd0;
        BASE  = 32'd0;
        MOC   = 1'b0;
        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        CLR = 1'b0;

        // STMIA r0,r2 at 0x100 with writeback.
        run_seq("stmia", mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 16'h0005), 32'h0000_0100,
                2, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0108, 0);
        // LDMDB r0,r15 below 0x200 with writeback.
        run_seq("ldmdb", mk_ir(1'b1, 1'b0, 1'b1, 1'b1, 16'h8001), 32'h0000_0200,
                1, 1'b0, 1'b0, 32'h0000_01F8, 1'b1, 1'b1, 32'h0000_01F8, 0);
        // LDMIB all sixteen registers, no writeback, MOC toggled outside XFER.
        run_seq("ldmib", mk_ir(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF), 32'h0000_1000,
                0, 1'b1, 1'b0, 32'h0000_1004, 1'b1, 1'b0, 32'h0, 0);
        // STMIA across the top of the address space.
        run_seq("wrap", mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 16'h0003), 32'hFFFF_FFFC,
                0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0000_0004, 0);
        // Empty list with W=1: no transfers, no writeback, DONE two cycles after START.
        run_seq("empty", mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000), 32'h0000_0500,
                0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2);
        // STMDA r1,r4,r7 below 0x300 with START held high throughout.
        run_seq("stmda", mk_ir(1'b0, 1'b0, 1'b1, 1'b0, 16'h0092), 32'h0000_0300,
                3, 1'b1, 1'b1, 32'h0000_02F8, 1'b0, 1'b1, 32'h0000_02F4, 0);

        // Reset while a transfer is waiting for MOC.
        begin
            bit saw_req = 1'b0;
            int done_seen = 0;
            @(negedge CLK);
            START = 1'b1;
            IR    = mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 16'h0003);
            BASE  = 32'h0000_0400;
            @(negedge CLK);
            START = 1'b0;
            for (int c = 0; c < 10 && !saw_req; c++) begin
                if (MEM_REQ) saw_req = 1'b1;
                else @(negedge CLK);
            end
            check("clr req_seen", 32'(saw_req), 32'd1);
            check("clr req_addr", MAR_OUT, 32'h0000_0400);
            @(negedge CLK);
            CLR = 1'b1;
            @(negedge CLK);
            CLR = 1'b0;
            check_idle_outputs("clr");
            for (int c = 0; c < 6; c++) begin
                if (DONE || BUSY) done_seen++;
                @(negedge CLK);
            end
            check("clr no_done", 32'(done_seen), 32'd0);
        end

        run_seq("after_clr", mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 16'h0005), 32'h0000_0100,
                0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0108, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
